// File: rtl/sub_intf_pkg.sv
// Shared constants and the count-width helper for the sub_intf event counter.
package sub_intf_pkg;

  localparam int A_MAX = 65535;
  localparam int D_MAX = 16;

  // Bits needed to hold any value from 0 up to and including the terminal count.
  function automatic int cw_of(input int term);
    return $clog2(term + 1);
  endfunction

endpackage

// File: rtl/sub_intf_delay.sv
// Fixed-depth register chain that delays a 1-bit level by D cycles (D=0 is a wire).
module sub_intf_delay
  import sub_intf_pkg::*;
#(
  parameter int D = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  if (D < 0 || D > D_MAX) begin : g_bad_depth
    $error("sub_intf_delay: D=%0d outside 0..%0d", D, D_MAX);
  end

  if (D == 0) begin : g_pass
    assign out = in;
  end else begin : g_chain
    logic [D-1:0] stages_r;

    // Shift the input through the chain; reset flushes any event in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        stages_r <= {D{1'b0}};
      end else begin
        stages_r[0] <= in;
        for (int i = 1; i < D; i++) begin
          stages_r[i] <= stages_r[i-1];
        end
      end
    end

    assign out = stages_r[D-1];
  end

endmodule

// File: rtl/sub_intf.sv
// Delayed event counter with registered terminal-count pulse.
// Define SUB_INTF_OVF_EN to add the sticky ovf output.
module sub_intf
  import sub_intf_pkg::*;
#(
  parameter int  A  = 1,
  parameter int  D  = 1,
  localparam int CW = cw_of(A)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          clr,
  output logic          a_dly,
  output logic [CW-1:0] count,
`ifdef SUB_INTF_OVF_EN
  output logic          ovf,
`endif
  output logic          hit
);

  if (A < 1 || A > A_MAX) begin : g_bad_term
    $error("sub_intf: A=%0d outside 1..%0d", A, A_MAX);
  end

  localparam logic [CW-1:0] TERM_M1 = CW'(A - 1);

  logic          a_dly_s;
  logic          wrap_s;
  logic [CW-1:0] count_r;
  logic          hit_r;

  sub_intf_delay #(.D(D)) u_delay (
    .clk (clk),
    .rst (rst),
    .in  (a),
    .out (a_dly_s)
  );

  // The counter only ever sees the delayed level.
  assign wrap_s = a_dly_s && (count_r == TERM_M1);

  // Count delayed events, wrapping at A with a single-cycle hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      hit_r   <= 1'b0;
    end else if (clr) begin
      count_r <= {CW{1'b0}};
      hit_r   <= 1'b0;
    end else if (wrap_s) begin
      count_r <= {CW{1'b0}};
      hit_r   <= 1'b1;
    end else if (a_dly_s) begin
      count_r <= count_r + CW'(1);
      hit_r   <= 1'b0;
    end else begin
      count_r <= count_r;
      hit_r   <= 1'b0;
    end
  end

`ifdef SUB_INTF_OVF_EN
  logic ovf_r;

  // Sticky flag: set on the same edge that raises hit, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (wrap_s && !clr) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign a_dly = a_dly_s;
  assign count = count_r;
  assign hit   = hit_r;

endmodule

// File: tb/tb_sub_intf.sv
// Directed bench for sub_intf: three parameterisations sharing one clock.
module tb_sub_intf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A=100, D=1
  logic rst0, a0, clr0, a_dly0, hit0;
  logic [6:0] count0;
  // A=1, D=0
  logic rst1, a1, clr1, a_dly1, hit1;
  logic [0:0] count1;
  // A=4, D=3
  logic rst2, a2, clr2, a_dly2, hit2;
  logic [2:0] count2;
`ifdef SUB_INTF_OVF_EN
  logic ovf0, ovf1, ovf2;
`endif

  sub_intf #(.A(100), .D(1)) u_a100 (
    .clk(clk), .rst(rst0), .a(a0), .clr(clr0), .a_dly(a_dly0), .count(count0),
`ifdef SUB_INTF_OVF_EN
    .ovf(ovf0),
`endif
    .hit(hit0)
  );

  sub_intf #(.A(1), .D(0)) u_a1 (
    .clk(clk), .rst(rst1), .a(a1), .clr(clr1), .a_dly(a_dly1), .count(count1),
`ifdef SUB_INTF_OVF_EN
    .ovf(ovf1),
`endif
    .hit(hit1)
  );

  sub_intf #(.A(4), .D(3)) u_a4 (
    .clk(clk), .rst(rst2), .a(a2), .clr(clr2), .a_dly(a_dly2), .count(count2),
`ifdef SUB_INTF_OVF_EN
    .ovf(ovf2),
`endif
    .hit(hit2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_hit;
    int   n_ev;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    step();
    step();
    check_eq("rst_count0", 32'(count0), 32'd0);
    check_eq("rst_hit0", 32'(hit0), 32'd0);
    check_eq("rst_dly0", 32'(a_dly0), 32'd0);
    check_eq("rst_hit1", 32'(hit1), 32'd0);
    check_eq("rst_count2", 32'(count2), 32'd0);
    check_eq("rst_dly2", 32'(a_dly2), 32'd0);

    // Idle after reset release
    rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_count0", 32'(count0), 32'd0);
      check_eq("idle_hit0", 32'(hit0), 32'd0);
      check_eq("idle_dly0", 32'(a_dly0), 32'd0);
    end

    // Continuous events through the first wrap and beyond
    a0 = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      step();
      check_eq("run_dly0", 32'(a_dly0), 32'd1);
      check_eq("run_count0", 32'(count0), 32'((k - 1) % 100));
      check_eq("run_hit0", 32'(hit0), (k == 101) ? 32'd1 : 32'd0);
`ifdef SUB_INTF_OVF_EN
      check_eq("run_ovf0", 32'(ovf0), (k >= 101) ? 32'd1 : 32'd0);
`endif
    end

    // clr overrides a live event and leaves ovf alone
    clr0 = 1'b1;
    step();
    check_eq("clr_count0", 32'(count0), 32'd0);
    check_eq("clr_hit0", 32'(hit0), 32'd0);
`ifdef SUB_INTF_OVF_EN
    check_eq("clr_ovf0", 32'(ovf0), 32'd1);
`endif
    // Delay chain still holds the last 1, so one more increment, then hold
    clr0 = 1'b0;
    a0 = 1'b0;
    step();
    check_eq("tail_count0", 32'(count0), 32'd1);
    step();
    check_eq("hold_count0", 32'(count0), 32'd1);
    check_eq("hold_dly0", 32'(a_dly0), 32'd0);

    // rst beats clr and a
    rst0 = 1'b1; clr0 = 1'b1; a0 = 1'b1;
    step();
    check_eq("rstprio_count0", 32'(count0), 32'd0);
    check_eq("rstprio_dly0", 32'(a_dly0), 32'd0);
`ifdef SUB_INTF_OVF_EN
    check_eq("rst_ovf0", 32'(ovf0), 32'd0);
`endif
    rst0 = 1'b0; clr0 = 1'b0; a0 = 1'b0;
    step();

    // 50 events, clear, restart from 0
    a0 = 1'b1;
    for (int k = 1; k <= 50; k++) step();
    check_eq("pre_clr_count0", 32'(count0), 32'd49);
    clr0 = 1'b1;
    step();
    check_eq("clr2_count0", 32'(count0), 32'd0);
    check_eq("clr2_hit0", 32'(hit0), 32'd0);
    clr0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("restart_count0", 32'(count0), 32'(k));
    end

    // A=1, D=0: a_dly follows a combinationally, hit on every event
    rst1 = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      a1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      check_eq("comb_dly1", 32'(a_dly1), 32'(a1));
      exp_hit = a1;
      step();
      check_eq("tog_hit1", 32'(hit1), 32'(exp_hit));
      check_eq("tog_count1", 32'(count1), 32'd0);
    end
    a1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("b2b_hit1", 32'(hit1), 32'd1);
      check_eq("b2b_count1", 32'(count1), 32'd0);
    end
    a1 = 1'b0;

    // A=4, D=3: event in flight is discarded by reset
    rst2 = 1'b0;
    step();
    a2 = 1'b1;
    step();
    check_eq("flight_dly2_e1", 32'(a_dly2), 32'd0);
    a2 = 1'b0;
    step();
    check_eq("flight_dly2_e2", 32'(a_dly2), 32'd0);
    rst2 = 1'b1;
    step();
    check_eq("flight_dly2_rst", 32'(a_dly2), 32'd0);
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("flight_dly2", 32'(a_dly2), 32'd0);
      check_eq("flight_count2", 32'(count2), 32'd0);
    end

    // A=4, D=3: D-cycle latency, then wraps every 4 events
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    a2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_ev = (k >= 4) ? (k - 3) : 0;
      check_eq("lat_dly2", 32'(a_dly2), (k >= 3) ? 32'd1 : 32'd0);
      check_eq("lat_count2", 32'(count2), 32'(n_ev % 4));
      check_eq("lat_hit2", 32'(hit2), (n_ev > 0 && n_ev % 4 == 0) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
